// File: rtl/debounce_one_pulse.sv
// Push-button conditioner: synchronizer, shift-chain debouncer and a press/long-hold FSM
// that emits a single-cycle press strobe and optional auto-repeat strobes while held.
module debounce_one_pulse #(
    parameter int DEPTH         = 4,
    parameter int HOLD_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 100,
    parameter int REPEAT_EN     = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic pb_in,
    output logic pb_debounced,
    output logic pb_pulse,
    output logic pb_held
);

    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        LONG
    } state_t;

    logic             sync1;
    logic             sync2;
    logic [DEPTH-1:0] chain;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Debounced level only moves once the whole chain agrees; mixed chains hold the old level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            chain        <= '0;
            pb_debounced <= 1'b0;
        end else begin
            sync1 <= pb_in;
            sync2 <= sync1;
            chain <= {chain[DEPTH-2:0], sync2};
            if (&chain)
                pb_debounced <= 1'b1;
            else if (~|chain)
                pb_debounced <= 1'b0;
        end
    end

    // A low debounced level in PRESS/LONG always wins, so a release can never strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            pb_pulse <= 1'b0;
            pb_held  <= 1'b0;
        end else begin
            pb_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    pb_held <= 1'b0;
                    if (pb_debounced) begin
                        state    <= PRESS;
                        pb_pulse <= 1'b1;
                        cnt      <= '0;
                    end
                end
                PRESS: begin
                    if (!pb_debounced) begin
                        state   <= IDLE;
                        pb_held <= 1'b0;
                        cnt     <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        state   <= LONG;
                        pb_held <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                LONG: begin
                    if (!pb_debounced) begin
                        state   <= IDLE;
                        pb_held <= 1'b0;
                        cnt     <= '0;
                    end else if (REPEAT_EN != 0) begin
                        if (cnt == REP_LAST) begin
                            pb_pulse <= 1'b1;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pb_held <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/debounce_one_pulse.md
DEBOUNCE_ONE_PULSE -- requirements
Module: debounce_one_pulse

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the debounce shift-chain length (legal 2..16).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 1000, giving the cycles from the press pulse to long-hold detection (legal >= 2).
REQ-003 The block SHALL have parameter REPEAT_CYCLES, default 100, giving the auto-repeat pulse period (legal >= 2).
REQ-004 The block SHALL have parameter REPEAT_EN, default 0, where 1 enables auto-repeat pulses.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port pb_in, input, 1 bit: raw asynchronous push-button level, active-high.
REQ-008 The block SHALL have port pb_debounced, output, 1 bit: registered, debounced button level.
REQ-009 The block SHALL have port pb_pulse, output, 1 bit: single-cycle press and auto-repeat strobe.
REQ-010 The block SHALL have port pb_held, output, 1 bit: high while a long hold is in progress.

Function
REQ-011 The block SHALL pass pb_in through a 2-flop synchronizer (sync1, sync2) before any other logic uses it.
REQ-012 Each edge, the block SHALL shift sync2 into a DEPTH-bit shift chain.
REQ-013 pb_debounced SHALL be set on the edge after the chain is all ones, SHALL be cleared on the edge after the chain is all zeros, and SHALL otherwise hold its value.
REQ-014 Latency: with pb_in stable high starting before edge 1, pb_debounced SHALL rise at edge DEPTH+3; the falling latency SHALL be identical.
REQ-015 The FSM SHALL have states IDLE, PRESS and LONG, with a cycle counter cnt wide enough for max(HOLD_CYCLES, REPEAT_CYCLES).
REQ-016 IDLE: on the edge after pb_debounced goes 0->1, the FSM SHALL go to PRESS, SHALL assert pb_pulse for exactly one cycle, and SHALL set cnt=0.
REQ-017 PRESS: cnt SHALL increment each edge; when cnt reaches HOLD_CYCLES-1, the FSM SHALL go to LONG, SHALL set pb_held=1, SHALL set cnt=0, and SHALL emit no pulse.
REQ-018 The pb_held rising edge SHALL therefore occur HOLD_CYCLES edges after the press-pulse edge.
REQ-019 LONG with REPEAT_EN=1: pb_pulse SHALL assert for one cycle every REPEAT_CYCLES edges, the first one REPEAT_CYCLES edges after pb_held rises, with cnt wrapping to 0 at each pulse.
REQ-020 LONG with REPEAT_EN=0: no pulses SHALL occur and cnt SHALL saturate.
REQ-021 In PRESS or LONG, pb_debounced=0 SHALL take precedence over everything else: next edge the FSM goes to IDLE, pb_held=0, cnt=0, and no pulse is emitted.
REQ-022 Releasing the button SHALL never generate a pulse.
REQ-023 Simultaneous release and repeat-due in the same cycle: release SHALL win, with no pulse.
REQ-024 pb_pulse SHALL never be high on two consecutive cycles.
REQ-025 pb_pulse SHALL never be high in IDLE.
REQ-026 Every output SHALL be a direct flop output, with no combinational path from pb_in to any output.

Reset
REQ-027 While reset=0 at a rising edge, the block SHALL clear sync1, sync2, the shift chain, pb_debounced, pb_pulse, pb_held and cnt to 0, and SHALL set the state to IDLE.
REQ-028 Reset SHALL override all other behaviour, including mid-press and mid-repeat.
REQ-029 After reset, a still-pressed button SHALL re-debounce from zero and SHALL produce a fresh press pulse; no pulse is lost or duplicated due to reset.

Verification (DEPTH=4, HOLD_CYCLES=10, REPEAT_CYCLES=3 unless stated)
REQ-030 Scenario: reset=0 for 3 edges with pb_in=1, then reset=1 -> all outputs 0 during reset; pb_debounced=1 at edge 7 after release; pb_pulse high only during cycle 8.
REQ-031 Scenario: pb_in bounces 1,0,1,1,0,1,0 on successive cycles, then holds 0 -> pb_debounced, pb_pulse and pb_held stay 0 throughout.
REQ-032 Scenario: REPEAT_EN=0, clean press held 30 cycles, then release -> exactly one pulse at edge P; pb_held rises at P+10; pb_held falls DEPTH+3 edges after pb_in falls plus one; no release pulse.
REQ-033 Scenario: REPEAT_EN=1, press held 40 cycles -> pulses at P, P+13, P+16, P+19, ... until release; no two adjacent pulse cycles.
REQ-034 Scenario: REPEAT_EN=1, release timed so pb_debounced falls in the cycle a repeat pulse is due -> no pulse; state IDLE next edge.
REQ-035 Scenario: reset=0 for 1 edge while in LONG with pb_in still high -> outputs 0 next cycle; new press pulse at edge 8 after reset release.
